// File: rtl/rvfi_seq_pkg.sv
// Shared types and parameter legality helper for the RVFI BMC sequencer.
package rvfi_seq_pkg;

   typedef enum logic [1:0] {
      PH_RST   = 2'd0,
      PH_RUN   = 2'd1,
      PH_CHECK = 2'd2,
      PH_DONE  = 2'd3
   } phase_t;

   // Legal parameter set: the depth must land strictly after core reset
   // release and strictly below the saturation point of the cycle counter,
   // otherwise the depth compare could never fire or could fire twice.
   function automatic bit seq_params_ok(
      input int unsigned nret,
      input int unsigned cnt_w,
      input int unsigned reset_cycles,
      input int unsigned check_depth
   );
      logic [63:0] cnt_max;
      cnt_max = (64'd1 << cnt_w) - 64'd1;
      return (nret >= 1) && (cnt_w >= 2) && (cnt_w <= 31) &&
             (check_depth > reset_cycles) &&
             (64'(check_depth) < cnt_max);
   endfunction

endpackage

// File: rtl/rvfi_popcount_sat.sv
// Popcount of the retire strobes plus a saturating add into a CNT_W counter.
module rvfi_popcount_sat
   import rvfi_seq_pkg::*;
#(
   parameter int unsigned NRET  = 1,
   parameter int unsigned CNT_W = 8
) (
   input  logic [NRET-1:0]  valid,
   input  logic             enable,
   input  logic [CNT_W-1:0] count_in,
   output logic [CNT_W-1:0] count_out
);

   localparam int unsigned PC_W  = $clog2(NRET + 1);
   localparam int unsigned SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [PC_W-1:0]  pc;
   logic [SUM_W-1:0] sum;

   // Count active channels, add with one guard bit, clamp on overflow.
   always_comb begin
      pc = '0;
      for (int unsigned i = 0; i < NRET; i++) begin
         pc = pc + PC_W'(valid[i]);
      end
      sum = SUM_W'(count_in);
      if (enable) begin
         sum = SUM_W'(count_in) + SUM_W'(pc);
      end
      if (sum > SUM_W'(CNT_MAX)) begin
         count_out = CNT_MAX;
      end else begin
         count_out = sum[CNT_W-1:0];
      end
   end

endmodule

// File: rtl/rvfi_bmc_sequencer.sv
// Sequences one BMC run: holds the core in reset, counts retirements,
// fires a single-cycle checker enable at depth and reports vacuity/stalls.
module rvfi_bmc_sequencer
   import rvfi_seq_pkg::*;
#(
   parameter int unsigned NRET         = 1,
   parameter int unsigned CNT_W        = 8,
   parameter int unsigned RESET_CYCLES = 5,
   parameter int unsigned CHECK_DEPTH  = 20,
   parameter int unsigned MIN_RETIRE   = 0,
   parameter int unsigned WATCHDOG     = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [NRET-1:0]  rvfi_valid,
   output logic             core_reset,
   output logic             checker_enable,
   output logic [CNT_W-1:0] cycle,
   output logic [CNT_W-1:0] retire_count,
   output logic [1:0]       phase,
   output logic             vacuous,
   output logic             stall
);

   if (!seq_params_ok(NRET, CNT_W, RESET_CYCLES, CHECK_DEPTH)) begin : g_bad_params
      $error("rvfi_bmc_sequencer: illegal NRET/CNT_W/RESET_CYCLES/CHECK_DEPTH combination");
   end

   logic [CNT_W-1:0] cycle_q, cycle_d;
   logic [CNT_W-1:0] retire_q, retire_d;
   logic [CNT_W-1:0] idle_q, idle_d;
   logic             core_reset_q, core_reset_d;
   logic             checker_enable_q, checker_enable_d;
   logic             vacuous_q, vacuous_d;
   logic             stall_q, stall_d;
   phase_t           phase_q, phase_d;

   logic at_depth;
   logic retire_ok;

   // Retirements only count once the core is out of reset.
   rvfi_popcount_sat #(
      .NRET  (NRET),
      .CNT_W (CNT_W)
   ) u_retire_add (
      .valid     (rvfi_valid),
      .enable    (~core_reset_q),
      .count_in  (retire_q),
      .count_out (retire_d)
   );

   // Next-state logic for counters, phase FSM, enable and sticky flags.
   always_comb begin
      cycle_d = (cycle_q == '1) ? cycle_q : cycle_q + CNT_W'(1);

      // Registered from the next cycle value so core_reset tracks the
      // visible cycle count: high while cycle < RESET_CYCLES.
      core_reset_d = (32'(cycle_d) < RESET_CYCLES);

      // The depth compare uses the next retire count, so a retirement in
      // the depth cycle itself still counts toward MIN_RETIRE.
      at_depth  = (phase_q == PH_RUN) && (32'(cycle_q) == CHECK_DEPTH);
      retire_ok = (32'(retire_d) >= MIN_RETIRE);

      checker_enable_d = at_depth && retire_ok;
      vacuous_d        = vacuous_q || (at_depth && !retire_ok);

      phase_d = phase_q;
      case (phase_q)
         PH_RST:   if (!core_reset_d) phase_d = PH_RUN;
         PH_RUN:   if (at_depth)      phase_d = PH_CHECK;
         PH_CHECK: phase_d = PH_DONE;
         default:  phase_d = PH_DONE;
      endcase

      idle_d  = idle_q;
      stall_d = stall_q;
      if (phase_q == PH_RUN) begin
         if (|rvfi_valid) begin
            idle_d = '0;
         end else if (idle_q != '1) begin
            idle_d = idle_q + CNT_W'(1);
         end
         if ((WATCHDOG != 0) && (32'(idle_d) == WATCHDOG)) begin
            stall_d = 1'b1;
         end
      end
   end

   // State registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         cycle_q          <= '0;
         retire_q         <= '0;
         idle_q           <= '0;
         core_reset_q     <= 1'b1;
         checker_enable_q <= 1'b0;
         vacuous_q        <= 1'b0;
         stall_q          <= 1'b0;
         phase_q          <= PH_RST;
      end else begin
         cycle_q          <= cycle_d;
         retire_q         <= retire_d;
         idle_q           <= idle_d;
         core_reset_q     <= core_reset_d;
         checker_enable_q <= checker_enable_d;
         vacuous_q        <= vacuous_d;
         stall_q          <= stall_d;
         phase_q          <= phase_d;
      end
   end

   assign core_reset     = core_reset_q;
   assign checker_enable = checker_enable_q;
   assign cycle          = cycle_q;
   assign retire_count   = retire_q;
   assign phase          = phase_q;
   assign vacuous        = vacuous_q;
   assign stall          = stall_q;

endmodule
